// File: rtl/window_sr_if.sv
// Handshake bundle between a pixel source, the window controller and the window consumer.
interface window_sr_if #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
);
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, in_valid, win_ready,
        input  in_ready, shift_en, win_valid, win_row, win_col, busy, frame_done
    );

    modport slave (
        input  start, in_valid, win_ready,
        output in_ready, shift_en, win_valid, win_row, win_col, busy, frame_done
    );
endinterface

// File: rtl/window_sr_ctrl.sv
// Sliding-window controller: tracks raster position of streamed pixels and
// announces each complete KERNELxKERNEL window held in the line-buffer chain.
module window_sr_ctrl #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned KERNEL = 3
) (
    input  logic        clock,
    input  logic        reset,
    window_sr_if.slave  bus
);
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          win_valid_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    logic          busy_q;
    logic          frame_done_q;

    logic in_ready;
    logic accept;
    logic handshake;
    logic last_col;
    logic qualify;

    // A pixel may enter only while streaming and while the window slot can take a new one.
    assign in_ready  = ((state == FILL) || (state == STREAM)) && (!win_valid_q || bus.win_ready);
    assign accept    = bus.in_valid && in_ready;
    assign handshake = win_valid_q && bus.win_ready;
    assign last_col  = (col == CW'(IMG_W - 1));
    assign qualify   = (int'(row) >= int'(KERNEL) - 1) && (int'(col) >= int'(KERNEL) - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // A new window replaces a consumed one in the same cycle, so no bubble.
            if (accept && qualify) begin
                win_valid_q <= 1'b1;
                win_row_q   <= row - RW'(KERNEL - 1);
                win_col_q   <= col - CW'(KERNEL - 1);
            end else if (handshake) begin
                win_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row    <= '0;
                        col    <= '0;
                        busy_q <= 1'b1;
                        state  <= (KERNEL == 1) ? STREAM : FILL;
                    end
                end
                FILL, STREAM: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if ((state == FILL) && (int'(row) == int'(KERNEL) - 2) && last_col) begin
                            state <= STREAM;
                        end
                        if ((state == STREAM) && (row == RW'(IMG_H - 1)) && last_col) begin
                            state <= DONE;
                            row   <= '0;
                            col   <= '0;
                        end
                    end
                end
                DONE: begin
                    // Wait for the final window to drain before signalling completion.
                    if (!win_valid_q || bus.win_ready) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.shift_en   = accept;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_window_sr_ctrl.sv
// Randomized bench for window_sr_ctrl against a transaction-level raster model.
module tb_window_sr_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    window_sr_if #(.IMG_W(8), .IMG_H(8)) b0();
    window_sr_if #(.IMG_W(4), .IMG_H(4)) b1();

    window_sr_ctrl #(.IMG_W(8), .IMG_H(8), .KERNEL(3)) dut0 (
        .clock(clock), .reset(reset), .bus(b0)
    );
    window_sr_ctrl #(.IMG_W(4), .IMG_H(4), .KERNEL(1)) dut1 (
        .clock(clock), .reset(reset), .bus(b1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit sel;
    int W, H, K;
    bit m_busy, m_pend_v, m_done;
    int m_pr, m_pc, m_pix;
    int raster[$];
    int n_win, n_shift, n_acc, last_r, last_c;
    bit seen_first;

    task automatic drive(input bit st, input bit iv, input bit wrd);
        b0.start     = sel ? 1'b0 : st;
        b0.in_valid  = sel ? 1'b0 : iv;
        b0.win_ready = sel ? 1'b0 : wrd;
        b1.start     = sel ? st  : 1'b0;
        b1.in_valid  = sel ? iv  : 1'b0;
        b1.win_ready = sel ? wrd : 1'b0;
    endtask

    task automatic init_frame();
        raster.delete();
        for (int r = 0; r <= H - K; r++)
            for (int c = 0; c <= W - K; c++)
                raster.push_back(r * 256 + c);
        n_win = 0; n_shift = 0; n_acc = 0; seen_first = 0;
        last_r = -1; last_c = -1;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input bit st, input bit iv, input bit wrd, input bit rst);
        bit ir, se, wv, bz, fd, exp_ir, acc, hs, nd, was_done, pend_before;
        int wr, wc, n, r, c, q;
        @(negedge clock);
        reset = rst;
        drive(st, iv, wrd);
        #1;
        if (!sel) begin
            ir = b0.in_ready; se = b0.shift_en; wv = b0.win_valid; bz = b0.busy; fd = b0.frame_done;
            wr = int'(b0.win_row); wc = int'(b0.win_col);
        end else begin
            ir = b1.in_ready; se = b1.shift_en; wv = b1.win_valid; bz = b1.busy; fd = b1.frame_done;
            wr = int'(b1.win_row); wc = int'(b1.win_col);
        end
        n = W * H;
        exp_ir = m_busy && (m_pix < n) && (!m_pend_v || wrd);
        check_eq("busy", int'(bz), int'(m_busy));
        check_eq("frame_done", int'(fd), int'(m_done));
        check_eq("win_valid", int'(wv), int'(m_pend_v));
        check_eq("in_ready", int'(ir), int'(exp_ir));
        check_eq("shift_en", int'(se), int'(iv && exp_ir));
        if (m_pend_v) begin
            check_eq("win_row", wr, m_pr);
            check_eq("win_col", wc, m_pc);
        end
        if (se) n_shift++;
        if (wv && !seen_first) begin
            seen_first = 1;
            check_eq("first_win_accepts", n_acc, (K - 1) * W + K);
        end
        if (wv && wrd) begin
            n_win++;
            last_r = wr; last_c = wc;
            if (raster.size() > 0) begin
                q = raster.pop_front();
                check_eq("raster_row", wr, q / 256);
                check_eq("raster_col", wc, q % 256);
            end else begin
                check_eq("raster_overrun", wr * 256 + wc, -1);
            end
        end

        acc = iv && exp_ir;
        hs  = m_pend_v && wrd;
        nd  = 0;
        if (rst) begin
            m_busy = 0; m_pend_v = 0; m_pix = 0;
        end else if (!m_busy) begin
            if (st) begin m_busy = 1; m_pix = 0; end
        end else begin
            was_done    = (m_pix == n);
            pend_before = m_pend_v;
            if (acc) begin
                r = m_pix / W; c = m_pix % W;
                m_pix++; n_acc++;
                if (r >= K - 1 && c >= K - 1) begin
                    m_pend_v = 1; m_pr = r - K + 1; m_pc = c - K + 1;
                end else if (hs) begin
                    m_pend_v = 0;
                end
            end else if (hs) begin
                m_pend_v = 0;
            end
            if (was_done && (!pend_before || wrd)) begin
                m_busy = 0; nd = 1;
            end
        end
        m_done = nd;
    endtask

    task automatic run_frame(input int iv_pct, input int rdy_pct, input bit noise, input bit stall);
        bit done, stalled, iv, wrd, st;
        done = 0; stalled = 0;
        init_frame();
        step(1, 0, 1, 0);
        for (int i = 0; i < 3000 && !done; i++) begin
            if (stall && !stalled && m_pend_v) begin
                for (int j = 0; j < 5; j++) step(0, 1, 0, 0);
                stalled = 1;
            end
            iv  = ($urandom_range(99) < iv_pct);
            wrd = ($urandom_range(99) < rdy_pct);
            st  = noise && m_busy && ($urandom_range(2) == 0);
            step(st, iv, wrd, 0);
            if (m_done) begin
                step(0, 0, 1, 0);
                done = 1;
            end
        end
        check_eq("frame_timeout", int'(done), 1);
        check_eq("windows", n_win, (W - K + 1) * (H - K + 1));
        check_eq("shifts", n_shift, W * H);
        check_eq("last_row", last_r, H - K);
        check_eq("last_col", last_c, W - K);
        check_eq("raster_left", raster.size(), 0);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        repeat (2) @(posedge clock);
        m_busy = 0; m_pend_v = 0; m_done = 0; m_pix = 0;
        step(0, 0, 1, 0);
    endtask

    initial begin
        sel = 0; W = 8; H = 8; K = 3;
        hard_reset();

        run_frame(100, 100, 0, 0);
        run_frame(100, 60, 0, 1);
        run_frame(50, 100, 0, 0);

        // Mid-frame reset at the 40th accept abandons the frame.
        init_frame();
        step(1, 0, 1, 0);
        for (int i = 0; i < 500 && m_pix < 39; i++) step(0, 1, 1, 0);
        check_eq("abort_position", m_pix, 39);
        step(0, 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        run_frame(100, 100, 0, 0);

        run_frame(70, 80, 1, 0);

        sel = 1; W = 4; H = 4; K = 1;
        hard_reset();
        run_frame(60, 70, 0, 0);
        run_frame(100, 100, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_sr_ctrl.md
WINDOW_SR_CTRL -- requirements
Module: window_sr_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (>= KERNEL).
REQ-002 SHALL have parameter IMG_H, default 8, image height in pixels (>= KERNEL).
REQ-003 SHALL have parameter KERNEL, default 3, square window size (>= 1).
REQ-004 SHALL have port clock  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  reset is synchronous and active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-007 SHALL have port in_valid  in  1  upstream pixel available.
REQ-008 SHALL have port in_ready  out  1  controller accepts a pixel this cycle.
REQ-009 SHALL have port shift_en  out  1  advance the line-buffer shift-register chain.
REQ-010 SHALL have port win_valid  out  1  a full KERNELxKERNEL window is present.
REQ-011 SHALL have port win_ready  in  1  downstream consumes the window.
REQ-012 SHALL have port win_row  out  clog2(IMG_H)  top-left row of the current window.
REQ-013 SHALL have port win_col  out  clog2(IMG_W)  top-left column of the current window.
REQ-014 SHALL have port busy  out  1  high whenever the controller is not in IDLE.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement states IDLE, FILL, STREAM and DONE.
REQ-017 SHALL define accept = in_valid & in_ready, and drive shift_en = accept combinationally.
REQ-018 SHALL drive in_ready = (state is FILL or STREAM) & (!win_valid | win_ready).
REQ-019 SHALL clear the row and column counters and move IDLE -> FILL on start; if KERNEL = 1, it SHALL move IDLE -> STREAM instead.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL increment col on each accept, wrap col from IMG_W-1 to 0, and increment row on that wrap.
REQ-022 SHALL move FILL -> STREAM on the accept at row = KERNEL-2, col = IMG_W-1.
REQ-023 SHALL, on an accept where row >= KERNEL-1 and col >= KERNEL-1, register win_valid = 1 for the next cycle, with win_row = row-(KERNEL-1) and win_col = col-(KERNEL-1).
REQ-024 SHALL hold win_valid, win_row and win_col stable until win_valid & win_ready.
REQ-025 SHALL clear win_valid after that handshake unless a new qualifying accept occurs in the same cycle; in that case the new window is loaded (back-to-back, no bubble).
REQ-026 SHALL produce exactly (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1) windows per frame, in raster order.
REQ-027 SHALL move STREAM -> DONE on the accept at row = IMG_H-1, col = IMG_W-1.
REQ-028 SHALL hold in_ready = 0 in DONE.
REQ-029 SHALL, in DONE, when win_valid = 0 or win_valid & win_ready, assert frame_done for exactly the next cycle and enter IDLE.
REQ-030 SHALL drive busy = 1 in FILL, STREAM and DONE, and 0 in IDLE.
REQ-031 SHALL leave the counters unchanged when in_valid = 1 and in_ready = 0; no pixel is lost or duplicated.

Reset
REQ-032 SHALL, on any clock edge with reset = 1, enter IDLE and zero the row and column counters.
REQ-033 SHALL, on that same edge, zero win_valid, win_row, win_col, frame_done and busy; in_ready and shift_en are 0 in the following cycle.
REQ-034 SHALL give reset priority over start and over an accept in the same cycle; a mid-frame reset abandons the frame with no frame_done.

Verification
REQ-035 SHALL pass: defaults, start, in_valid = 1 and win_ready = 1 continuously -> first win_valid the cycle after the 19th accept (win_row = 0, win_col = 0); 36 windows total; last window win_row = 5, win_col = 5; frame_done one cycle after the last window handshake.
REQ-036 SHALL pass: backpressure, win_ready = 0 for 5 cycles while win_valid = 1 -> in_ready = 0, shift_en = 0, and win_row/win_col stable throughout; resume with no skipped or repeated window.
REQ-037 SHALL pass: in_valid toggling randomly at 50% -> same 36-window raster sequence as REQ-035; shift_en pulses exactly 64 times.
REQ-038 SHALL pass: reset asserted mid-STREAM at the 40th accept -> next cycle busy = 0 and win_valid = 0; no frame_done; a new start gives a full 36-window frame.
REQ-039 SHALL pass: start pulsed while busy -> no effect on counters or window sequence.
REQ-040 SHALL pass: KERNEL = 1, IMG_W = IMG_H = 4 -> 16 windows, one per accept, each win_row/win_col equal to the accepted pixel coordinate.
